// File: rtl/nonce_search_ctrl_pkg.sv
// Shared definitions for the nonce search controller: nonce width and the
// FSM state encoding used by the controller.
package nonce_search_ctrl_pkg;

  localparam int NONCE_W = 32;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ISSUE  = 3'd1;
  localparam state_t S_WAIT   = 3'd2;
  localparam state_t S_REPORT = 3'd3;
  localparam state_t S_DONE   = 3'd4;

endpackage

// File: rtl/hash_watchdog.sv
// Watchdog for the hash core handshake. Counts enabled cycles since the last
// clear and flags expiry once the count reaches TIMEOUT_CYCLES-1; it then
// holds until cleared.
module hash_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cycle counter: cleared on request, saturates at the expiry value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nonce_search_ctrl.sv
// Nonce search controller: walks an inclusive (possibly wrapping) nonce range,
// launching the hash core for each nonce and reporting the first hit, range
// exhaustion, or a hash core timeout. All outputs are registered.
module nonce_search_ctrl
  import nonce_search_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_first,
  input  logic [NONCE_W-1:0] nonce_last,
  input  logic               hash_done,
  input  logic               hash_hit,
  output logic               hash_start,
  output logic [NONCE_W-1:0] hash_nonce,
  output logic               valid,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               exhausted,
  output logic               timeout
);

  state_t             state, state_n;
  logic [NONCE_W-1:0] cur, cur_n;
  logic [NONCE_W-1:0] last, last_n;
  logic               wd_clear;
  logic               wd_enable;
  logic               wd_expired;
  logic               report_ok;

  // The counter is zeroed on entry to ISSUE so it reads 0 during ISSUE and
  // counts ISSUE plus every WAIT cycle spent waiting for the hash core.
  assign wd_clear  = (state_n == S_ISSUE);
  assign wd_enable = (state == S_ISSUE) || (state == S_WAIT);

  // Abort squashes any pulse that would otherwise leave REPORT or DONE.
  assign report_ok = (state == S_REPORT) && !abort;

  hash_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  // Next-state and range-walk logic; abort overrides every other transition.
  always_comb begin
    state_n = state;
    cur_n   = cur;
    last_n  = last;
    case (state)
      S_IDLE: begin
        if (start) begin
          cur_n   = nonce_first;
          last_n  = nonce_last;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (hash_done) begin
          if (hash_hit) begin
            state_n = S_REPORT;
          end else if (cur == last) begin
            state_n = S_DONE;
          end else begin
            cur_n   = cur + NONCE_W'(1);
            state_n = S_ISSUE;
          end
        end else if (wd_expired) begin
          state_n = S_IDLE;
        end
      end
      S_REPORT: state_n = S_IDLE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      state_n = S_IDLE;
    end
  end

  // State, range registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cur        <= '0;
      last       <= '0;
      hash_start <= 1'b0;
      hash_nonce <= '0;
      valid      <= 1'b0;
      nonce      <= '0;
      busy       <= 1'b0;
      exhausted  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      cur        <= cur_n;
      last       <= last_n;
      hash_start <= (state_n == S_ISSUE);
      hash_nonce <= (state_n == S_ISSUE) ? cur_n : '0;
      valid      <= report_ok;
      nonce      <= report_ok ? cur : '0;
      busy       <= (state_n != S_IDLE);
      exhausted  <= (state == S_DONE) && !abort;
      timeout    <= (state == S_WAIT) && !abort && !hash_done && wd_expired;
    end
  end

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Scoreboard bench for nonce_search_ctrl: directed searches push expected
// hash launches and result pulses into queues; a monitor pops and compares
// whenever the DUT emits one.
module tb_nonce_search_ctrl;
  import nonce_search_ctrl_pkg::*;

  localparam int TMO = 8;
  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_EXH   = 2'd2;
  localparam logic [1:0] K_TMO   = 2'd3;

  typedef struct {
    logic [1:0]         kind;
    logic [NONCE_W-1:0] n;
  } evt_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               abort;
  logic [NONCE_W-1:0] nonce_first;
  logic [NONCE_W-1:0] nonce_last;
  logic               hash_done;
  logic               hash_hit;
  logic               hash_start;
  logic [NONCE_W-1:0] hash_nonce;
  logic               valid;
  logic [NONCE_W-1:0] nonce;
  logic               busy;
  logic               exhausted;
  logic               timeout;

  logic [NONCE_W-1:0] exp_iss_q[$];
  evt_t               exp_evt_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hit_cyc = 0;

  nonce_search_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .nonce_first(nonce_first),
    .nonce_last (nonce_last),
    .hash_done  (hash_done),
    .hash_hit   (hash_hit),
    .hash_start (hash_start),
    .hash_nonce (hash_nonce),
    .valid      (valid),
    .nonce      (nonce),
    .busy       (busy),
    .exhausted  (exhausted),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every launch and every result pulse must match the queue head.
  initial begin
    logic [NONCE_W-1:0] e;
    evt_t               ev;
    logic [1:0]         k;
    forever begin
      @(negedge clk);
      if (hash_start === 1'b1) begin
        checks++;
        if (exp_iss_q.size() == 0) begin
          errors++;
          $display("FAIL issue: got hash_start nonce=%h, expected no launch", hash_nonce);
        end else begin
          e = exp_iss_q.pop_front();
          if (hash_nonce !== e) begin
            errors++;
            $display("FAIL issue: got nonce=%h, expected %h", hash_nonce, e);
          end
        end
      end
      if ((valid | exhausted | timeout) === 1'b1) begin
        checks++;
        if ({1'b0, valid} + {1'b0, exhausted} + {1'b0, timeout} != 2'd1) k = 2'd0;
        else if (valid)     k = K_VALID;
        else if (exhausted) k = K_EXH;
        else                k = K_TMO;
        if (exp_evt_q.size() == 0) begin
          errors++;
          $display("FAIL result: got kind=%0d nonce=%h, expected no pulse", k, nonce);
        end else begin
          ev = exp_evt_q.pop_front();
          if (k !== ev.kind || nonce !== ev.n) begin
            errors++;
            $display("FAIL result: got kind=%0d nonce=%h, expected kind=%0d nonce=%h",
                     k, nonce, ev.kind, ev.n);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string nm, input logic [NONCE_W-1:0] act,
                          input logic [NONCE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push_evt(input logic [1:0] k, input logic [NONCE_W-1:0] n);
    evt_t ev;
    ev.kind = k;
    ev.n    = n;
    exp_evt_q.push_back(ev);
  endtask

  task automatic do_start(input logic [NONCE_W-1:0] f, input logic [NONCE_W-1:0] l);
    tick();
    start       = 1'b1;
    nonce_first = f;
    nonce_last  = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_issue(output bit ok, output logic [NONCE_W-1:0] n);
    ok = 1'b0;
    n  = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hash_start === 1'b1) begin
        ok = 1'b1;
        n  = hash_nonce;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_issue: no hash_start within 40 cycles, expected one");
    end
  endtask

  // Hash core model: answer each launch two cycles into WAIT.
  task automatic serve(input int cnt, input bit hit_en, input logic [NONCE_W-1:0] hit_n);
    bit                 ok;
    logic [NONCE_W-1:0] cn;
    for (int i = 0; i < cnt; i++) begin
      wait_issue(ok, cn);
      if (!ok) return;
      tick();
      tick();
      hash_done = 1'b1;
      hash_hit  = hit_en && (cn == hit_n);
      if (hash_hit) hit_cyc = cyc;
      tick();
      hash_done = 1'b0;
      hash_hit  = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(nm, {31'd0, ok}, 32'd1);
  endtask

  // Stimulus: directed searches with hand-computed expectations.
  initial begin
    bit                 ok;
    logic [NONCE_W-1:0] cn;
    int                 t0;

    reset = 1'b0; start = 1'b0; abort = 1'b0;
    nonce_first = '0; nonce_last = '0; hash_done = 1'b0; hash_hit = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_hash_start", {31'd0, hash_start}, 32'd0);
    check_eq("rst_hash_nonce", hash_nonce, 32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_nonce", nonce, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_exhausted", {31'd0, exhausted}, 32'd0);
    check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
    tick();
    reset = 1'b1;

    // Hit on 0x12 inside 0x10..0x13; 0x13 must never launch.
    exp_iss_q.push_back(32'h10); exp_iss_q.push_back(32'h11); exp_iss_q.push_back(32'h12);
    push_evt(K_VALID, 32'h12);
    do_start(32'h10, 32'h13);
    check_eq("busy_after_start", {31'd0, busy}, 32'd1);
    serve(3, 1'b1, 32'h12);
    t0 = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        t0 = cyc - hit_cyc;
        break;
      end
    end
    check_eq("hit_to_valid_latency", t0, 32'd2);
    wait_idle("idle_after_hit");
    repeat (6) tick();

    // No hit in 0x20..0x22: three launches then exhausted.
    exp_iss_q.push_back(32'h20); exp_iss_q.push_back(32'h21); exp_iss_q.push_back(32'h22);
    push_evt(K_EXH, 32'h0);
    do_start(32'h20, 32'h22);
    serve(3, 1'b0, 32'h0);
    wait_idle("idle_after_exhaust");
    repeat (4) tick();

    // Wrapping range FFFFFFFE..00000001.
    exp_iss_q.push_back(32'hFFFF_FFFE); exp_iss_q.push_back(32'hFFFF_FFFF);
    exp_iss_q.push_back(32'h0);         exp_iss_q.push_back(32'h1);
    push_evt(K_EXH, 32'h0);
    do_start(32'hFFFF_FFFE, 32'h0000_0001);
    serve(4, 1'b0, 32'h0);
    wait_idle("idle_after_wrap");
    repeat (4) tick();

    // Single-nonce range: exactly one launch.
    exp_iss_q.push_back(32'h55);
    push_evt(K_EXH, 32'h0);
    do_start(32'h55, 32'h55);
    serve(1, 1'b0, 32'h0);
    wait_idle("idle_after_single");
    repeat (4) tick();

    // Hash core never answers: timeout 8 cycles after the launch cycle.
    exp_iss_q.push_back(32'h30);
    push_evt(K_TMO, 32'h0);
    do_start(32'h30, 32'h35);
    wait_issue(ok, cn);
    t0 = cyc;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("timeout_seen", {31'd0, ok}, 32'd1);
    check_eq("timeout_delay", cyc - t0, 32'd8);
    check_eq("busy_at_timeout", {31'd0, busy}, 32'd0);
    repeat (4) tick();

    // Abort together with a hit: back to IDLE, no valid.
    exp_iss_q.push_back(32'h40);
    do_start(32'h40, 32'h45);
    wait_issue(ok, cn);
    tick();
    hash_done = 1'b1; hash_hit = 1'b1; abort = 1'b1;
    tick();
    hash_done = 1'b0; hash_hit = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_eq("busy_after_abort", {31'd0, busy}, 32'd0);
    repeat (6) tick();

    // Reset during WAIT; a late hash_done is ignored, then a new search runs.
    exp_iss_q.push_back(32'h50);
    do_start(32'h50, 32'h52);
    wait_issue(ok, cn);
    tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    hash_done = 1'b1; hash_hit = 1'b1;
    tick();
    hash_done = 1'b0; hash_hit = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("post_rst_valid", {31'd0, valid}, 32'd0);
    check_eq("post_rst_nonce", nonce, 32'd0);
    check_eq("post_rst_hash_start", {31'd0, hash_start}, 32'd0);
    exp_iss_q.push_back(32'h60);
    push_evt(K_VALID, 32'h60);
    do_start(32'h60, 32'h60);
    serve(1, 1'b1, 32'h60);
    wait_idle("idle_after_restart");
    repeat (6) tick();

    check_eq("issue_queue_drained", exp_iss_q.size(), 32'd0);
    check_eq("result_queue_drained", exp_evt_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
